// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single RAM device port.
// Each access runs as a fixed arbitrate / issue / respond sequence.

package pkg_ram;
   parameter int unsigned RAM_ADDRW = 32;
   typedef enum logic [1:0] {RAM_NOP = 2'd0, RAM_FETCH = 2'd1, RAM_STORE = 2'd2} ram_op_t;
   typedef enum logic [1:0] {RAM_BYTE, RAM_HALF, RAM_WORD, RAM_LONG} ram_size_t;
endpackage

module ram_arbiter #(
   parameter int unsigned ADDRW = pkg_ram::RAM_ADDRW,
   parameter int unsigned DATAW = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  pkg_ram::ram_op_t    m0_op,
   input  pkg_ram::ram_size_t  m0_size,
   input  logic [ADDRW-1:0]    m0_addr,
   input  logic [DATAW-1:0]    m0_data_in,
   output logic                m0_gnt,
   output logic                m0_valid,
   output logic [DATAW-1:0]    m0_data_out,
   input  logic                m1_req,
   input  pkg_ram::ram_op_t    m1_op,
   input  pkg_ram::ram_size_t  m1_size,
   input  logic [ADDRW-1:0]    m1_addr,
   input  logic [DATAW-1:0]    m1_data_in,
   output logic                m1_gnt,
   output logic                m1_valid,
   output logic [DATAW-1:0]    m1_data_out,
   output pkg_ram::ram_op_t    ram_op,
   output pkg_ram::ram_size_t  ram_size,
   output logic [ADDRW-1:0]    ram_addr,
   output logic [DATAW-1:0]    ram_data_in,
   input  logic [DATAW-1:0]    ram_data_out
);
   import pkg_ram::*;

   typedef enum logic [1:0] {StArb, StIssue, StResp} state_t;

   state_t            state_q;
   logic              last_gnt_q;
   logic              owner_q;
   ram_op_t           op_q;
   ram_size_t         size_q;
   logic [ADDRW-1:0]  addr_q;
   logic [DATAW-1:0]  wdata_q;
   logic [DATAW-1:0]  m0_rdata_q;
   logic [DATAW-1:0]  m1_rdata_q;

   logic elig0, elig1, any_elig, win1, resp_fetch;

   always_comb begin
      elig0    = m0_req && (m0_op != RAM_NOP);
      elig1    = m1_req && (m1_op != RAM_NOP);
      any_elig = elig0 || elig1;
      // On a tie the master that did not win last time goes next.
      win1     = elig1 && (!elig0 || !last_gnt_q);
   end

   assign resp_fetch  = (state_q == StResp) && (op_q == RAM_FETCH);

   assign m0_gnt      = (state_q == StArb) && elig0 && !win1;
   assign m1_gnt      = (state_q == StArb) && win1;
   assign m0_valid    = (state_q == StResp) && !owner_q;
   assign m1_valid    = (state_q == StResp) && owner_q;
   assign m0_data_out = (resp_fetch && !owner_q) ? ram_data_out : m0_rdata_q;
   assign m1_data_out = (resp_fetch && owner_q) ? ram_data_out : m1_rdata_q;

   assign ram_op      = (state_q == StIssue) ? op_q : RAM_NOP;
   assign ram_size    = size_q;
   assign ram_addr    = addr_q;
   assign ram_data_in = ((state_q == StIssue) && (op_q == RAM_STORE)) ? wdata_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StArb;
         last_gnt_q <= 1'b1;
         owner_q    <= 1'b0;
         op_q       <= RAM_NOP;
         size_q     <= RAM_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         unique case (state_q)
            StArb: begin
               if (any_elig) begin
                  owner_q    <= win1;
                  last_gnt_q <= win1;
                  op_q       <= win1 ? m1_op : m0_op;
                  size_q     <= win1 ? m1_size : m0_size;
                  addr_q     <= win1 ? m1_addr : m0_addr;
                  wdata_q    <= win1 ? m1_data_in : m0_data_in;
                  state_q    <= StIssue;
               end
            end
            StIssue: state_q <= StResp;
            StResp: begin
               if (op_q == RAM_FETCH) begin
                  if (owner_q) m1_rdata_q <= ram_data_out;
                  else         m0_rdata_q <= ram_data_out;
               end
               state_q <= StArb;
            end
            default: state_q <= StArb;
         endcase
      end
   end

endmodule
